// File: rtl/jt10_adpcm_pkg.sv
// jt10_adpcm_pkg
//   Shared definitions for the ADPCM-A channel sequencer.
//   - PAGE_BITS: low byte-address bits below a start/end page (256-byte pages).
//   - ptr_width(): nibble-pointer width for a given byte-address width.
//   - slot_act_e: what the sequencer does with the channel in the current slot.
//   - Flag vectors use bit k = channel k throughout.
package jt10_adpcm_pkg;

    localparam int PAGE_BITS = 8;

    // A nibble pointer is the byte address plus one nibble-select bit.
    function automatic int ptr_width(input int addr_w);
        return addr_w + 1;
    endfunction

    typedef enum logic [2:0] {
        ACT_IDLE,
        ACT_KEYON,
        ACT_DUMP,
        ACT_PLAY,
        ACT_STOP,
        ACT_LOOP
    } slot_act_e;

endpackage

// File: rtl/jt10_adpcm_chseq_if.sv
// jt10_adpcm_chseq_if
//   Register-side bus from the MMR block into the channel sequencer.
//   master: MMR block (drives everything); slave: sequencer.
//   ch_addr/addr_in/up_start/up_end/loop_in/up_loop : per-channel register writes
//   aon_mask/aon_dump/up_aon                        : key-on / dump command
//   clr_flags                                       : level clear of end flags
interface jt10_adpcm_chseq_if #(
    parameter int NCH    = 6,
    parameter int CHW    = 3,
    parameter int ADDR_W = 24
);
    import jt10_adpcm_pkg::*;

    localparam int PAGE_W = ADDR_W - PAGE_BITS;

    logic [CHW-1:0]    ch_addr;
    logic [PAGE_W-1:0] addr_in;
    logic              up_start;
    logic              up_end;
    logic              loop_in;
    logic              up_loop;
    logic [NCH-1:0]    aon_mask;
    logic              aon_dump;
    logic              up_aon;
    logic [NCH-1:0]    clr_flags;

    modport master (
        output ch_addr, addr_in, up_start, up_end, loop_in, up_loop,
               aon_mask, aon_dump, up_aon, clr_flags
    );

    modport slave (
        input  ch_addr, addr_in, up_start, up_end, loop_in, up_loop,
               aon_mask, aon_dump, up_aon, clr_flags
    );

endinterface

// File: rtl/jt10_adpcm_chram.sv
// jt10_adpcm_chram
//   NCH-deep per-channel state file {on, loop, start, end, ptr}.
//   rd_*      : async read of entry rd_idx_i
//   seq_*     : sequencer write of {on, ptr} at seq_idx_i
//   host_*    : register write of start/end/loop at host_idx_i; indices >= NCH ignored
//   The two write ports own disjoint fields, so both land when they hit one entry.
//   Build option JT10_ADPCM_LOOP_EN: store the loop bit; otherwise loop reads as 0.
module jt10_adpcm_chram
    import jt10_adpcm_pkg::*;
#(
    parameter int NCH    = 6,
    parameter int CHW    = 3,
    parameter int ADDR_W = 24,
    parameter int PAGE_W = ADDR_W - PAGE_BITS,
    parameter int PTR_W  = ptr_width(ADDR_W)
) (
    input  logic              rst_n,
    input  logic              clk,
    input  logic [CHW-1:0]    rd_idx_i,
    output logic              rd_on_o,
    output logic              rd_loop_o,
    output logic [PAGE_W-1:0] rd_start_o,
    output logic [PAGE_W-1:0] rd_end_o,
    output logic [PTR_W-1:0]  rd_ptr_o,
    input  logic              seq_we_i,
    input  logic [CHW-1:0]    seq_idx_i,
    input  logic              seq_on_i,
    input  logic [PTR_W-1:0]  seq_ptr_i,
    input  logic [CHW-1:0]    host_idx_i,
    input  logic              host_start_we_i,
    input  logic              host_end_we_i,
    input  logic              host_loop_we_i,
    input  logic [PAGE_W-1:0] host_page_i,
    input  logic              host_loop_i
);
    logic              on_q    [NCH];
    logic [PAGE_W-1:0] start_q [NCH];
    logic [PAGE_W-1:0] end_q   [NCH];
    logic [PTR_W-1:0]  ptr_q   [NCH];
    logic              host_ok;

    assign host_ok = (int'(host_idx_i) < NCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                on_q[i]    <= 1'b0;
                start_q[i] <= '0;
                end_q[i]   <= '0;
                ptr_q[i]   <= '0;
            end
        end else begin
            if (seq_we_i) begin
                on_q[seq_idx_i]  <= seq_on_i;
                ptr_q[seq_idx_i] <= seq_ptr_i;
            end
            if (host_ok && host_start_we_i) start_q[host_idx_i] <= host_page_i;
            if (host_ok && host_end_we_i)   end_q[host_idx_i]   <= host_page_i;
        end
    end

    assign rd_on_o    = on_q[rd_idx_i];
    assign rd_start_o = start_q[rd_idx_i];
    assign rd_end_o   = end_q[rd_idx_i];
    assign rd_ptr_o   = ptr_q[rd_idx_i];

`ifdef JT10_ADPCM_LOOP_EN
    logic [NCH-1:0] loop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loop_q <= '0;
        end else if (host_ok && host_loop_we_i) begin
            loop_q[host_idx_i] <= host_loop_i;
        end
    end

    assign rd_loop_o = loop_q[rd_idx_i];
`else
    logic unused_loop;
    assign unused_loop = host_loop_we_i ^ host_loop_i;
    assign rd_loop_o   = 1'b0;
`endif

endmodule

// File: rtl/jt10_adpcm_chseq.sv
// jt10_adpcm_chseq
//   Parametrised ADPCM-A channel sequencer. One channel slot per cen_i; every
//   output is registered for the slot just processed (one cen of latency).
//   Ports: rst_n/clk, cen_i slot advance, mmr (register bus, slave),
//          cur_ch_o/slot_o/frame_o slot identity, addr_o/sel_o/roe_n_o ROM fetch,
//          decon_o/clr_dec_o decoder control, flags_o sticky end-of-sample flags.
//   Build option JT10_ADPCM_LOOP_EN enables per-channel looping (in jt10_adpcm_chram).
//
//   slot action | meaning
//   ACT_IDLE    | channel off, no command: ROM disabled, addr/sel held
//   ACT_KEYON   | pending key-on: restart at start page, clear decoder
//   ACT_DUMP    | pending dump: channel off, no flag
//   ACT_PLAY    | fetch current nibble, advance pointer
//   ACT_STOP    | fetch last nibble, channel off, set flag
//   ACT_LOOP    | fetch last nibble, pointer back to start page
module jt10_adpcm_chseq
    import jt10_adpcm_pkg::*;
#(
    parameter int NCH    = 6,
    parameter int CHW    = 3,
    parameter int ADDR_W = 24
) (
    input  logic               rst_n,
    input  logic               clk,
    input  logic               cen_i,
    jt10_adpcm_chseq_if.slave  mmr,
    output logic [NCH-1:0]     cur_ch_o,
    output logic [CHW-1:0]     slot_o,
    output logic               frame_o,
    output logic [ADDR_W-1:0]  addr_o,
    output logic               sel_o,
    output logic               roe_n_o,
    output logic               decon_o,
    output logic               clr_dec_o,
    output logic [NCH-1:0]     flags_o
);
    localparam int PAGE_W = ADDR_W - PAGE_BITS;
    localparam int PTR_W  = ptr_width(ADDR_W);
    localparam logic [CHW-1:0] LAST = CHW'(NCH - 1);

    logic [CHW-1:0]    s_q, s_d;
    logic [NCH-1:0]    pend_mask_q;
    logic              pend_dump_q;
    logic [NCH-1:0]    cur_ch_q, flags_q, flags_d, flag_set;
    logic [CHW-1:0]    slot_q;
    logic              frame_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              sel_q, sel_d, roe_n_q, roe_n_d, decon_q, decon_d, clr_dec_q, clr_dec_d;

    logic              rd_on, rd_loop, seq_on, at_end;
    logic [PAGE_W-1:0] rd_start, rd_end;
    logic [PTR_W-1:0]  rd_ptr, seq_ptr, start_ptr;
    slot_act_e         act;

    jt10_adpcm_chram #(
        .NCH    (NCH),
        .CHW    (CHW),
        .ADDR_W (ADDR_W),
        .PAGE_W (PAGE_W),
        .PTR_W  (PTR_W)
    ) u_chram (
        .rst_n           (rst_n),
        .clk             (clk),
        .rd_idx_i        (s_q),
        .rd_on_o         (rd_on),
        .rd_loop_o       (rd_loop),
        .rd_start_o      (rd_start),
        .rd_end_o        (rd_end),
        .rd_ptr_o        (rd_ptr),
        .seq_we_i        (cen_i),
        .seq_idx_i       (s_q),
        .seq_on_i        (seq_on),
        .seq_ptr_i       (seq_ptr),
        .host_idx_i      (mmr.ch_addr),
        .host_start_we_i (mmr.up_start),
        .host_end_we_i   (mmr.up_end),
        .host_loop_we_i  (mmr.up_loop),
        .host_page_i     (mmr.addr_in),
        .host_loop_i     (mmr.loop_in)
    );

    assign s_d       = (s_q == LAST) ? '0 : s_q + 1'b1;
    assign start_ptr = {rd_start, {PAGE_BITS{1'b0}}, 1'b0};
    // Last nibble: low nibble of the final byte of the end page. An equality
    // test (not >=) lets a pointer with end < start wrap through 2^ADDR_W.
    assign at_end    = rd_ptr[0] && (rd_ptr[PTR_W-1:1] == {rd_end, {PAGE_BITS{1'b1}}});

    always_comb begin
        act = ACT_IDLE;
        if (pend_mask_q[s_q])  act = pend_dump_q ? ACT_DUMP : ACT_KEYON;
        else if (rd_on && at_end) act = rd_loop ? ACT_LOOP : ACT_STOP;
        else if (rd_on)        act = ACT_PLAY;
    end

    always_comb begin
        seq_on    = rd_on;
        seq_ptr   = rd_ptr;
        addr_d    = addr_q;
        sel_d     = sel_q;
        roe_n_d   = 1'b1;
        decon_d   = 1'b0;
        clr_dec_d = 1'b0;
        flag_set  = '0;
        case (act)
            ACT_KEYON: begin
                seq_on    = 1'b1;
                seq_ptr   = start_ptr + 1'b1;
                addr_d    = start_ptr[PTR_W-1:1];
                sel_d     = 1'b0;
                roe_n_d   = 1'b0;
                decon_d   = 1'b1;
                clr_dec_d = 1'b1;
            end
            ACT_DUMP: seq_on = 1'b0;
            ACT_PLAY, ACT_STOP, ACT_LOOP: begin
                addr_d  = rd_ptr[PTR_W-1:1];
                sel_d   = rd_ptr[0];
                roe_n_d = 1'b0;
                decon_d = 1'b1;
                if (act == ACT_PLAY) seq_ptr = rd_ptr + 1'b1;
                if (act == ACT_LOOP) seq_ptr = start_ptr;
                if (act == ACT_STOP) begin
                    seq_on         = 1'b0;
                    flag_set[s_q]  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // A new end on the same clk as a clear keeps the flag.
    assign flags_d = (flags_q & ~mmr.clr_flags) | (cen_i ? flag_set : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q         <= '0;
            pend_mask_q <= '0;
            pend_dump_q <= 1'b0;
            cur_ch_q    <= NCH'(1);
            slot_q      <= '0;
            frame_q     <= 1'b0;
            addr_q      <= '0;
            sel_q       <= 1'b0;
            roe_n_q     <= 1'b1;
            decon_q     <= 1'b0;
            clr_dec_q   <= 1'b0;
            flags_q     <= '0;
        end else begin
            flags_q <= flags_d;
            // A fresh command replaces the old one wholesale, so it must not
            // lose a bit to a consume landing on the same clk.
            if (mmr.up_aon) begin
                pend_mask_q <= mmr.aon_mask;
                pend_dump_q <= mmr.aon_dump;
            end else if (cen_i) begin
                pend_mask_q[s_q] <= 1'b0;
            end
            if (cen_i) begin
                s_q       <= s_d;
                cur_ch_q  <= NCH'(1) << s_q;
                slot_q    <= s_q;
                frame_q   <= (s_q == LAST);
                addr_q    <= addr_d;
                sel_q     <= sel_d;
                roe_n_q   <= roe_n_d;
                decon_q   <= decon_d;
                clr_dec_q <= clr_dec_d;
            end
        end
    end

    assign cur_ch_o  = cur_ch_q;
    assign slot_o    = slot_q;
    assign frame_o   = frame_q;
    assign addr_o    = addr_q;
    assign sel_o     = sel_q;
    assign roe_n_o   = roe_n_q;
    assign decon_o   = decon_q;
    assign clr_dec_o = clr_dec_q;
    assign flags_o   = flags_q;

endmodule

// File: tb/tb_jt10_adpcm_chseq.sv
// tb_jt10_adpcm_chseq
//   Directed bench: a 6-channel sequencer for the main scenarios and an
//   8-channel instance sharing clk/cen for the frame-length scenario.
module tb_jt10_adpcm_chseq;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic cen   = 1'b0;

    always #5 clk = ~clk;

    jt10_adpcm_chseq_if #(.NCH(6), .CHW(3), .ADDR_W(24)) m6 ();
    jt10_adpcm_chseq_if #(.NCH(8), .CHW(3), .ADDR_W(24)) m8 ();

    logic [5:0]  cur6, flags6;
    logic [2:0]  slot6;
    logic        frame6, sel6, roe6, decon6, clrd6;
    logic [23:0] addr6;
    logic [7:0]  cur8, flags8;
    logic [2:0]  slot8;
    logic        frame8, sel8, roe8, decon8, clrd8;
    logic [23:0] addr8;

    jt10_adpcm_chseq #(.NCH(6), .CHW(3), .ADDR_W(24)) dut6 (
        .rst_n(rst_n), .clk(clk), .cen_i(cen), .mmr(m6),
        .cur_ch_o(cur6), .slot_o(slot6), .frame_o(frame6), .addr_o(addr6),
        .sel_o(sel6), .roe_n_o(roe6), .decon_o(decon6), .clr_dec_o(clrd6),
        .flags_o(flags6)
    );

    jt10_adpcm_chseq #(.NCH(8), .CHW(3), .ADDR_W(24)) dut8 (
        .rst_n(rst_n), .clk(clk), .cen_i(cen), .mmr(m8),
        .cur_ch_o(cur8), .slot_o(slot8), .frame_o(frame8), .addr_o(addr8),
        .sel_o(sel8), .roe_n_o(roe8), .decon_o(decon8), .clr_dec_o(clrd8),
        .flags_o(flags8)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int nxt6     = 0;   // next slot each DUT will process
    int nxt8     = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [5:0] clr6);
        cen          = 1'b1;
        m6.clr_flags = clr6;
        @(posedge clk); #1;
        cen          = 1'b0;
        m6.clr_flags = '0;
        nxt6 = (nxt6 + 1) % 6;
        nxt8 = (nxt8 + 1) % 8;
    endtask

    task automatic run6(input int ch, input logic [5:0] clr6);
        while (nxt6 != ch) step(6'h00);
        step(clr6);
    endtask

    task automatic run8(input int ch);
        while (nxt8 != ch) step(6'h00);
        step(6'h00);
    endtask

    task automatic wr6(input int ch, input logic ws, input logic we, input logic wl,
                       input logic [15:0] page, input logic lp);
        m6.ch_addr = 3'(ch); m6.addr_in = page; m6.loop_in = lp;
        m6.up_start = ws; m6.up_end = we; m6.up_loop = wl;
        @(posedge clk); #1;
        m6.up_start = 1'b0; m6.up_end = 1'b0; m6.up_loop = 1'b0;
    endtask

    task automatic wr8(input int ch, input logic [15:0] page);
        m8.ch_addr = 3'(ch); m8.addr_in = page;
        m8.up_start = 1'b1; m8.up_end = 1'b1;
        @(posedge clk); #1;
        m8.up_start = 1'b0; m8.up_end = 1'b0;
    endtask

    task automatic aon6(input logic [5:0] mask, input logic dump);
        m6.aon_mask = mask; m6.aon_dump = dump; m6.up_aon = 1'b1;
        @(posedge clk); #1;
        m6.up_aon = 1'b0;
    endtask

    task automatic clr6_now(input logic [5:0] clr);
        m6.clr_flags = clr;
        @(posedge clk); #1;
        m6.clr_flags = '0;
    endtask

    // Key-on ch0 (start=end=0x0012) and follow all 512 nibbles of the page.
    task automatic play_ch0(input logic clr_last);
        logic [24:0] exp;
        aon6(6'h01, 1'b0);
        for (int n = 0; n < 512; n++) begin
            run6(0, (clr_last && n == 511) ? 6'h01 : 6'h00);
            exp = {24'h001200 + 24'(n / 2), 1'(n % 2)};
            check_eq("ch0_fetch", {7'd0, addr6, sel6}, {7'd0, exp});
            if (n == 0) begin
                check_eq("keyon_clr_dec", clrd6, 1);
                check_eq("keyon_decon", decon6, 1);
                check_eq("keyon_roe_n", roe6, 0);
            end
            if (n == 1) check_eq("play_clr_dec", clrd6, 0);
        end
    endtask

    initial begin
        m6.ch_addr = '0; m6.addr_in = '0; m6.up_start = 0; m6.up_end = 0; m6.loop_in = 0;
        m6.up_loop = 0; m6.aon_mask = '0; m6.aon_dump = 0; m6.up_aon = 0; m6.clr_flags = '0;
        m8.ch_addr = '0; m8.addr_in = '0; m8.up_start = 0; m8.up_end = 0; m8.loop_in = 0;
        m8.up_loop = 0; m8.aon_mask = '0; m8.aon_dump = 0; m8.up_aon = 0; m8.clr_flags = '0;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // reset values
        check_eq("rst_cur_ch", cur6, 1);
        check_eq("rst_slot", slot6, 0);
        check_eq("rst_frame", frame6, 0);
        check_eq("rst_addr_sel", {addr6, sel6}, 0);
        check_eq("rst_ctrl", {roe6, decon6, clrd6}, 3'b100);
        check_eq("rst_flags", flags6, 0);

        // slot walk, both channel counts
        for (int i = 0; i < 12; i++) begin
            step(6'h00);
            check_eq("walk_cur_ch", cur6, 32'(1 << (i % 6)));
            check_eq("walk_frame", frame6, 32'((i % 6) == 5));
            check_eq("walk_roe_n", roe6, 1);
            check_eq("walk8_cur_ch", cur8, 32'(1 << (i % 8)));
        end

        // single page play, no loop
        wr6(0, 1, 1, 0, 16'h0012, 0);
        play_ch0(1'b0);
        check_eq("end_flags", flags6, 6'h01);
        run6(0, 6'h00);
        check_eq("stopped_roe_n", roe6, 1);
        check_eq("stopped_decon", decon6, 0);

        // end flag set on the same clk as its clear: set wins
        play_ch0(1'b1);
        check_eq("set_over_clr", flags6, 6'h01);
        clr6_now(6'h01);
        check_eq("clr_flags", flags6, 6'h00);

        // dump ch3 while ch0 plays; restart ch0 while playing
        wr6(3, 1, 1, 0, 16'h0040, 0);
        aon6(6'h09, 1'b0);
        run6(3, 6'h00);
        check_eq("ch3_keyon", {7'd0, addr6, sel6, clrd6}, {7'd0, 24'h004000, 1'b0, 1'b1});
        run6(0, 6'h00);
        check_eq("ch0_keyon", {7'd0, addr6, sel6, clrd6}, {7'd0, 24'h001200, 1'b0, 1'b1});
        run6(3, 6'h00);
        check_eq("ch3_play", {7'd0, addr6, sel6, roe6}, {7'd0, 24'h004000, 1'b1, 1'b0});
        aon6(6'h08, 1'b1);
        run6(3, 6'h00);
        check_eq("ch3_dump_ctrl", {roe6, decon6}, 2'b10);
        check_eq("ch3_dump_flags", flags6, 6'h00);
        run6(0, 6'h00);
        check_eq("ch0_unaffected", {7'd0, addr6, sel6, roe6, decon6}, {7'd0, 24'h001201, 1'b0, 2'b01});
        aon6(6'h01, 1'b0);
        run6(0, 6'h00);
        check_eq("ch0_restart", {7'd0, addr6, sel6, clrd6}, {7'd0, 24'h001200, 1'b0, 1'b1});
        aon6(6'h01, 1'b1);
        run6(0, 6'h00);
        check_eq("ch0_dump", roe6, 1);

        // looping channel
        wr6(0, 0, 0, 1, 16'h0000, 1);
        play_ch0(1'b0);
`ifdef JT10_ADPCM_LOOP_EN
        check_eq("loop_flags", flags6, 6'h00);
        run6(0, 6'h00);
        check_eq("loop_refetch", {7'd0, addr6, sel6, clrd6, roe6}, {7'd0, 24'h001200, 1'b0, 2'b00});
        check_eq("loop_flags2", flags6, 6'h00);
`else
        check_eq("noloop_flags", flags6, 6'h01);
        run6(0, 6'h00);
        check_eq("noloop_stop", {roe6, decon6}, 2'b10);
`endif
        aon6(6'h01, 1'b1);
        run6(0, 6'h00);
        check_eq("loop_dump", roe6, 1);
        clr6_now(6'h3F);

        // out-of-range write ignored
        wr6(6, 1, 1, 0, 16'h0077, 0);
        aon6(6'h01, 1'b0);
        run6(0, 6'h00);
        check_eq("oor_write", {7'd0, addr6, sel6}, {7'd0, 24'h001200, 1'b0});
        aon6(6'h01, 1'b1);
        run6(0, 6'h00);

        // 8-channel frame with ch7 playing
        wr8(7, 16'h0300);
        m8.aon_mask = 8'h80; m8.aon_dump = 1'b0; m8.up_aon = 1'b1;
        @(posedge clk); #1;
        m8.up_aon = 1'b0;
        run8(7);
        check_eq("ch7_id", {cur8, slot8, frame8}, {8'h80, 3'd7, 1'b1});
        check_eq("ch7_keyon", {7'd0, addr8, sel8, clrd8}, {7'd0, 24'h030000, 1'b0, 1'b1});
        for (int i = 0; i < 7; i++) step(6'h00);
        check_eq("ch6_frame", {cur8, frame8}, {8'h40, 1'b0});
        step(6'h00);
        check_eq("ch7_next", {7'd0, cur8, addr8, sel8, clrd8, roe8}, {7'd0, 8'h80, 24'h030000, 1'b1, 2'b00});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
